// File: rtl/tdm_demux16.sv
// Receive-side 16:1 TDM demultiplexer: rebuilds serial words into dout with a valid strobe.
// Optional even-parity slot 16 is compiled in with `define TDM_DEMUX_PARITY_EN.
module tdm_demux16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        sync,
  input  logic        en,
  output logic [15:0] dout,
  output logic        valid,
  output logic [4:0]  slot,
  output logic        sync_err,
  output logic        par_err,
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_n;
  logic [15:0] shadow, shadow_n;
  logic [15:0] dout_n;
  logic [4:0]  slot_n;
  logic        valid_n, sync_err_n, par_err_n;

  // valid is a one-cycle strobe with no ready/backpressure: the consumer must
  // capture dout on the cycle valid is high; dout itself holds until the next frame.
  assign state_dbg = (state == RUN);

  always_comb begin
    state_n    = state;
    slot_n     = slot;
    shadow_n   = shadow;
    dout_n     = dout;
    valid_n    = 1'b0;
    sync_err_n = 1'b0;
    par_err_n  = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (sync) begin
            shadow_n[0] = din;
            slot_n      = 5'd1;
            state_n     = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // sync anywhere but slot 0 abandons the partial frame and restarts on this bit
            if (slot != 5'd0) sync_err_n = 1'b1;
            shadow_n[0] = din;
            slot_n      = 5'd1;
          end else if (slot == 5'd0) begin
            sync_err_n = 1'b1;
            state_n    = IDLE;
          end else if (slot == 5'd15) begin
            shadow_n[15] = din;
`ifdef TDM_DEMUX_PARITY_EN
            slot_n       = 5'd16;
`else
            dout_n       = {din, shadow[14:0]};
            valid_n      = 1'b1;
            slot_n       = 5'd0;
`endif
          end
`ifdef TDM_DEMUX_PARITY_EN
          else if (slot == 5'd16) begin
            // even parity: the parity bit equals the XOR of the data bits
            if (din == ^shadow) begin
              dout_n  = shadow;
              valid_n = 1'b1;
            end else begin
              par_err_n = 1'b1;
            end
            slot_n = 5'd0;
          end
`endif
          else begin
            shadow_n[slot[3:0]] = din;
            slot_n              = slot + 5'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      slot     <= 5'd0;
      shadow   <= 16'd0;
      dout     <= 16'd0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      state    <= state_n;
      slot     <= slot_n;
      shadow   <= shadow_n;
      dout     <= dout_n;
      valid    <= valid_n;
      sync_err <= sync_err_n;
      par_err  <= par_err_n;
    end
  end

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16: framing, back-to-back, enable gaps, sync errors, reset, parity.
module tb_tdm_demux16;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int nslot = 17;
`else
  localparam int nslot = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din = 1'b0;
  logic        sync = 1'b0;
  logic        en = 1'b0;
  logic [15:0] dout;
  logic        valid;
  logic [4:0]  slot;
  logic        sync_err;
  logic        par_err;
  logic        state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  tdm_demux16 dut (
    .clk(clk), .rst(rst), .din(din), .sync(sync), .en(en),
    .dout(dout), .valid(valid), .slot(slot), .sync_err(sync_err),
    .par_err(par_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // one rising edge with the given inputs; outputs are sampled 1 ns after it
  task automatic step(input logic d, input logic s, input logic e);
    din = d; sync = s; en = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [15:0] w, input int i);
    logic [3:0] k;
    k = i[3:0];
    if (i >= 16) return ^w;
    return w[k];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    vectors++;
    if ({dout, valid, slot, sync_err, par_err, state_dbg} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset: got dout=%h valid=%b slot=%0d serr=%b perr=%b st=%b, expected all zero",
               dout, valid, slot, sync_err, par_err, state_dbg);
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] w;
    w = 16'h0001;
    for (int i = 0; i < nslot; i++) begin
      step(fbit(w, i), i == 0, 1'b1);
      vectors++;
      if (valid !== (i == nslot - 1) || slot !== 5'((i + 1) % nslot)) begin
        miscompares++;
        $display("FAIL single_bit%0d: got valid=%b slot=%0d, expected valid=%b slot=%0d",
                 i, valid, slot, i == nslot - 1, (i + 1) % nslot);
      end
    end
    vectors++;
    if (dout !== 16'h0001 || state_dbg !== 1'b1) begin
      miscompares++;
      $display("FAIL single_dout: got %h st=%b, expected 0001 st=1", dout, state_dbg);
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse: got valid=%b, expected 0", valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [2];
    logic [15:0] exp;
    int last_valid;
    words[0] = 16'hA100;
    words[1] = 16'hD000;
    last_valid = -1;
    exp_q.push_back(words[0]);
    exp_q.push_back(words[1]);
    for (int i = 0; i < 2 * nslot; i++) begin
      step(fbit(words[i / nslot], i % nslot), (i % nslot) == 0, 1'b1);
      vectors++;
      if (sync_err !== 1'b0 || valid !== ((i % nslot) == nslot - 1)) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got valid=%b serr=%b, expected valid=%b serr=0",
                 i, valid, sync_err, (i % nslot) == nslot - 1);
      end
      if (valid === 1'b1) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        vectors++;
        if (dout !== exp) begin
          miscompares++;
          $display("FAIL b2b_dout: got %h expected %h", dout, exp);
        end
        if (last_valid >= 0) begin
          vectors++;
          if (i - last_valid != nslot) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d", i - last_valid, nslot);
          end
        end
        last_valid = i;
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d words left unseen, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_enable_gaps();
    logic [15:0] w;
    int cyc;
    w = 16'h0630;
    cyc = 0;
    for (int i = 0; i < nslot; i++) begin
      step(fbit(w, i), i == 0, 1'b1);
      cyc++;
      vectors++;
      if (valid !== (i == nslot - 1)) begin
        miscompares++;
        $display("FAIL gap_valid_bit%0d: got %b expected %b", i, valid, i == nslot - 1);
      end
      if (i == 4 || i == 11) begin
        for (int g = 0; g < 3; g++) begin
          // sync and din toggling while disabled must be ignored
          step(g[0], i == 4, 1'b0);
          cyc++;
          vectors++;
          if (slot !== 5'(i + 1) || valid !== 1'b0 || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_hold_%0d_%0d: got slot=%0d valid=%b serr=%b, expected slot=%0d 0 0",
                     i, g, slot, valid, sync_err, i + 1);
          end
        end
      end
    end
    vectors++;
    if (dout !== 16'h0630 || cyc != nslot + 6) begin
      miscompares++;
      $display("FAIL gap_dout: got %h at cycle %0d, expected 0630 at cycle %0d", dout, cyc, nslot + 6);
    end
  endtask

  task automatic test_early_sync();
    logic [15:0] a, b;
    a = 16'h8010;
    b = 16'h0C00;
    for (int i = 0; i < 9; i++) begin
      step(fbit(a, i), i == 0, 1'b1);
      vectors++;
      if (valid !== 1'b0 || sync_err !== 1'b0) begin
        miscompares++;
        $display("FAIL early_pre%0d: got valid=%b serr=%b, expected 0 0", i, valid, sync_err);
      end
    end
    step(fbit(b, 0), 1'b1, 1'b1);
    vectors++;
    if (sync_err !== 1'b1 || slot !== 5'd1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_sync: got serr=%b slot=%0d valid=%b, expected 1 1 0", sync_err, slot, valid);
    end
    for (int i = 1; i < nslot; i++) begin
      step(fbit(b, i), 1'b0, 1'b1);
      vectors++;
      if (valid !== (i == nslot - 1) || sync_err !== 1'b0) begin
        miscompares++;
        $display("FAIL early_post%0d: got valid=%b serr=%b, expected %b 0", i, valid, sync_err, i == nslot - 1);
      end
    end
    vectors++;
    if (dout !== 16'h0C00) begin
      miscompares++;
      $display("FAIL early_dout: got %h expected 0c00", dout);
    end
  endtask

  task automatic test_sync_at_last();
    logic [15:0] w;
    w = 16'h1234;
    for (int i = 0; i < 15; i++) step(fbit(w, i), i == 0, 1'b1);
    step(fbit(w, 15), 1'b1, 1'b1);
    vectors++;
    if (valid !== 1'b0 || sync_err !== 1'b1 || slot !== 5'd1 || dout !== 16'h0C00) begin
      miscompares++;
      $display("FAIL sync_last: got valid=%b serr=%b slot=%0d dout=%h, expected 0 1 1 0c00",
               valid, sync_err, slot, dout);
    end
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_missing_sync_reset();
    logic [15:0] w;
    w = 16'h4001;
    for (int i = 0; i < nslot; i++) step(fbit(w, i), i == 0, 1'b1);
    vectors++;
    if (dout !== 16'h4001 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_frame: got dout=%h valid=%b, expected 4001 1", dout, valid);
    end
    step(1'b1, 1'b0, 1'b1);
    vectors++;
    if (sync_err !== 1'b1 || state_dbg !== 1'b0 || slot !== 5'd0 || dout !== 16'h4001 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_sync: got serr=%b st=%b slot=%0d dout=%h valid=%b, expected 1 0 0 4001 0",
               sync_err, state_dbg, slot, dout, valid);
    end
    step(1'b1, 1'b0, 1'b0);
    vectors++;
    if (sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_pulse: got serr=%b expected 0", sync_err);
    end
    step(1'b1, 1'b0, 1'b1);
    vectors++;
    if (state_dbg !== 1'b0 || slot !== 5'd0 || sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_discard: got st=%b slot=%0d serr=%b, expected 0 0 0", state_dbg, slot, sync_err);
    end
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1);
    vectors++;
    if (slot !== 5'd5 || state_dbg !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame: got slot=%0d st=%b, expected 5 1", slot, state_dbg);
    end
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    vectors++;
    if (dout !== 16'h0000 || slot !== 5'd0 || state_dbg !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got dout=%h slot=%0d st=%b valid=%b, expected 0000 0 0 0",
               dout, slot, state_dbg, valid);
    end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    logic [15:0] w;
    w = 16'h0780;
    for (int i = 0; i < 17; i++) step((i < 16) ? fbit(w, i) : 1'b0, i == 0, 1'b1);
    vectors++;
    if (valid !== 1'b1 || dout !== 16'h0780 || par_err !== 1'b0) begin
      miscompares++;
      $display("FAIL par_good: got valid=%b dout=%h perr=%b, expected 1 0780 0", valid, dout, par_err);
    end
    w = 16'h0023;
    for (int i = 0; i < 17; i++) step((i < 16) ? fbit(w, i) : 1'b0, i == 0, 1'b1);
    vectors++;
    if (valid !== 1'b0 || dout !== 16'h0780 || par_err !== 1'b1 || slot !== 5'd0) begin
      miscompares++;
      $display("FAIL par_bad: got valid=%b dout=%h perr=%b slot=%0d, expected 0 0780 1 0",
               valid, dout, par_err, slot);
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (par_err !== 1'b0) begin
      miscompares++;
      $display("FAIL par_pulse: got perr=%b expected 0", par_err);
    end
  endtask
`else
  task automatic test_parity();
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (par_err !== 1'b0) begin
      miscompares++;
      $display("FAIL par_tied: got perr=%b expected 0", par_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enable_gaps();
    test_early_sync();
    test_sync_at_last();
    test_missing_sync_reset();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
